// File: rtl/ov7670_pkg.sv
// Shared types and camera geometry for the OV7670 capture path.
package ov7670_pkg;

  localparam int OV_H_ACTIVE = 640;
  localparam int OV_V_ACTIVE = 480;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  typedef enum logic [1:0] {
    S_SYNC,
    S_WAIT,
    S_ACTIVE
  } capture_state_t;

endpackage

// File: rtl/frame_buffer_writer_if.sv
// Frame-buffer BRAM write port: the writer drives, the BRAM side listens.
interface frame_buffer_writer_if #(
  parameter int ADDR_W = 19
);
  logic [ADDR_W-1:0] o_ADDR;
  logic [11:0]       o_DATA;
  logic              o_WE;

  modport master (output o_ADDR, output o_DATA, output o_WE);
  modport slave  (input  o_ADDR, input  o_DATA, input  o_WE);
endinterface

// File: rtl/sync_edge_detect.sv
// One-flop delay of a camera sync line with rise/fall strobes against the delayed copy.
module sync_edge_detect (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);
  logic d_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) d_q <= 1'b0;
    else         d_q <= d_i;
  end

  assign rise_o = d_i & ~d_q;
  assign fall_o = ~d_i & d_q;
endmodule

// File: rtl/frame_buffer_writer.sv
// Frames camera pixels on VSYNC/HREF, optionally decimates 2:1, and writes them to a frame-buffer BRAM.
module frame_buffer_writer
  import ov7670_pkg::*;
#(
  parameter int H_ACTIVE = OV_H_ACTIVE,
  parameter int V_ACTIVE = OV_V_ACTIVE,
  parameter int DECIM    = 1,
  parameter int ADDR_W   = 19
) (
  input  logic                  PCLK,
  input  logic                  RST_N,
  input  logic                  VSYNC,
  input  logic                  HREF,
  input  logic [11:0]           i_PIXEL,
  input  logic                  i_VALID,
  input  logic                  i_CAPTURE_EN,
  frame_buffer_writer_if.master wr,
  output logic                  o_FRAME_DONE,
  output logic                  o_FRAME_OK,
  output logic                  o_BUSY
);
  localparam int XW        = $clog2(H_ACTIVE + 1);
  localparam int YW        = $clog2(V_ACTIVE + 1);
  localparam int XSH       = (DECIM == 2) ? 1 : 0;
  localparam int LINE_STEP = H_ACTIVE / DECIM;

  if (DECIM != 1 && DECIM != 2) begin : g_bad_decim
    $error("frame_buffer_writer: DECIM must be 1 or 2");
  end
  if ((64'd1 << ADDR_W) < 64'((H_ACTIVE / DECIM) * (V_ACTIVE / DECIM))) begin : g_bad_addr_w
    $error("frame_buffer_writer: ADDR_W too small for the decimated frame");
  end

  logic vs_rise, vs_fall, hr_fall, hr_rise_unused;

  sync_edge_detect u_vs_edge (
    .clk_i (PCLK),
    .rst_ni(RST_N),
    .d_i   (VSYNC),
    .rise_o(vs_rise),
    .fall_o(vs_fall)
  );

  sync_edge_detect u_hr_edge (
    .clk_i (PCLK),
    .rst_ni(RST_N),
    .d_i   (HREF),
    .rise_o(hr_rise_unused),
    .fall_o(hr_fall)
  );

  capture_state_t    state_q, state_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              err_short_q, err_short_d;
  logic              err_long_q, err_long_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  rgb444_t           data_q, data_d;
  logic              we_q, we_d;
  logic              done_q, done_d;
  logic              ok_q, ok_d;

  logic pix_keep, line_keep;

  // Decimation keeps only even columns of even rows.
  assign pix_keep  = (x_q < XW'(H_ACTIVE)) && (y_q < YW'(V_ACTIVE)) &&
                     ((DECIM == 1) || (!x_q[0] && !y_q[0]));
  assign line_keep = (y_q < YW'(V_ACTIVE)) && ((DECIM == 1) || !y_q[0]);

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    base_d      = base_q;
    err_short_d = err_short_q;
    err_long_d  = err_long_q;
    addr_d      = addr_q;
    data_d      = data_q;
    we_d        = 1'b0;
    done_d      = 1'b0;
    ok_d        = ok_q;
    unique case (state_q)
      S_SYNC: if (VSYNC) state_d = S_WAIT;
      S_WAIT: begin
        if (vs_fall && i_CAPTURE_EN) begin
          state_d     = S_ACTIVE;
          x_d         = '0;
          y_d         = '0;
          base_d      = '0;
          err_short_d = 1'b0;
          err_long_d  = 1'b0;
        end
      end
      S_ACTIVE: begin
        // Pixel first with the old x/line_base, then line end, then frame close.
        if (i_VALID) begin
          if (pix_keep) begin
            we_d   = 1'b1;
            addr_d = base_q + ADDR_W'(x_q >> XSH);
            data_d = rgb444_t'(i_PIXEL);
          end
          if (x_q >= XW'(H_ACTIVE)) err_long_d = 1'b1;
          else                      x_d = x_q + 1'b1;
        end
        if (hr_fall) begin
          if (x_d != XW'(H_ACTIVE)) err_short_d = 1'b1;
          if (line_keep) base_d = base_q + ADDR_W'(LINE_STEP);
          if (y_q >= YW'(V_ACTIVE)) err_long_d = 1'b1;
          else                      y_d = y_q + 1'b1;
          x_d = '0;
        end
        if (vs_rise) begin
          state_d = S_WAIT;
          done_d  = 1'b1;
          ok_d    = (y_d == YW'(V_ACTIVE)) && !err_short_d && !err_long_d;
        end
      end
      default: state_d = S_SYNC;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (!RST_N) begin
      state_q     <= S_SYNC;
      x_q         <= '0;
      y_q         <= '0;
      base_q      <= '0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      we_q        <= 1'b0;
      done_q      <= 1'b0;
      ok_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      base_q      <= base_d;
      err_short_q <= err_short_d;
      err_long_q  <= err_long_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      we_q        <= we_d;
      done_q      <= done_d;
      ok_q        <= ok_d;
    end
  end

  assign wr.o_ADDR    = addr_q;
  assign wr.o_DATA    = data_q;
  assign wr.o_WE      = we_q;
  assign o_FRAME_DONE = done_q;
  assign o_FRAME_OK   = ok_q;
  assign o_BUSY       = (state_q == S_ACTIVE);
endmodule

// File: tb/tb_frame_buffer_writer.sv
// Drives one stimulus into a DECIM=1 and a DECIM=2 writer and checks both against a reference model.
module tb_frame_buffer_writer;
  localparam int H  = 4;
  localparam int V  = 3;
  localparam int AW = 4;

  logic PCLK, RST_N, VSYNC, HREF, VALID, CAP;
  logic [11:0] PIX;
  logic done1, ok1, busy1, done2, ok2, busy2;

  int checks = 0;
  int errors = 0;

  frame_buffer_writer_if #(.ADDR_W(AW)) wr1 ();
  frame_buffer_writer_if #(.ADDR_W(AW)) wr2 ();

  frame_buffer_writer #(.H_ACTIVE(H), .V_ACTIVE(V), .DECIM(1), .ADDR_W(AW)) u_d1 (
    .PCLK(PCLK), .RST_N(RST_N), .VSYNC(VSYNC), .HREF(HREF), .i_PIXEL(PIX),
    .i_VALID(VALID), .i_CAPTURE_EN(CAP), .wr(wr1),
    .o_FRAME_DONE(done1), .o_FRAME_OK(ok1), .o_BUSY(busy1));

  frame_buffer_writer #(.H_ACTIVE(H), .V_ACTIVE(V), .DECIM(2), .ADDR_W(AW)) u_d2 (
    .PCLK(PCLK), .RST_N(RST_N), .VSYNC(VSYNC), .HREF(HREF), .i_PIXEL(PIX),
    .i_VALID(VALID), .i_CAPTURE_EN(CAP), .wr(wr2),
    .o_FRAME_DONE(done2), .o_FRAME_OK(ok2), .o_BUSY(busy2));

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d (0x%0h) expected %0d (0x%0h)", nm, $time, act, act, exp, exp);
    end
  endtask

  // Reference model: frame/line/pixel bookkeeping in plain integers, index 0 -> DECIM 1, 1 -> DECIM 2.
  int m_ph[2], m_x[2], m_y[2], m_base[2];
  bit m_es[2], m_el[2];
  int e_addr[2], e_data[2];
  bit e_we[2], e_done[2], e_ok[2], e_busy[2];
  bit pvs, phr;

  always @(posedge PCLK) begin
    bit vr, vf, hf;
    int d;
    if (!RST_N) begin
      for (int k = 0; k < 2; k++) begin
        m_ph[k] = 0; m_x[k] = 0; m_y[k] = 0; m_base[k] = 0; m_es[k] = 0; m_el[k] = 0;
        e_addr[k] = 0; e_data[k] = 0; e_we[k] = 0; e_done[k] = 0; e_ok[k] = 0; e_busy[k] = 0;
      end
      pvs = 0; phr = 0;
    end else begin
      vr = VSYNC && !pvs;
      vf = !VSYNC && pvs;
      hf = !HREF && phr;
      for (int k = 0; k < 2; k++) begin
        d = k + 1;
        e_we[k] = 0;
        e_done[k] = 0;
        if (m_ph[k] == 0) begin
          if (VSYNC) m_ph[k] = 1;
        end else if (m_ph[k] == 1) begin
          if (vf && CAP) begin
            m_ph[k] = 2; m_x[k] = 0; m_y[k] = 0; m_base[k] = 0; m_es[k] = 0; m_el[k] = 0;
          end
        end else begin
          if (VALID) begin
            if (m_x[k] < H && m_y[k] < V && (d == 1 || (m_x[k] % 2 == 0 && m_y[k] % 2 == 0))) begin
              e_we[k] = 1; e_addr[k] = m_base[k] + m_x[k] / d; e_data[k] = int'(PIX);
            end
            if (m_x[k] >= H) m_el[k] = 1;
            else m_x[k]++;
          end
          if (hf) begin
            if (m_x[k] != H) m_es[k] = 1;
            if (m_y[k] < V && (d == 1 || m_y[k] % 2 == 0)) m_base[k] += H / d;
            if (m_y[k] >= V) m_el[k] = 1;
            else m_y[k]++;
            m_x[k] = 0;
          end
          if (vr) begin
            m_ph[k] = 1; e_done[k] = 1;
            e_ok[k] = (m_y[k] == V) && !m_es[k] && !m_el[k];
          end
        end
        e_busy[k] = (m_ph[k] == 2);
      end
      pvs = VSYNC; phr = HREF;
    end
  end

  // Per-cycle compare plus BRAM image, write count and frame-done history.
  int mem1[16], mem2[16];
  int wc1 = 0, wc2 = 0, dc1 = 0, dc2 = 0;
  bit lok1, lok2;

  always @(negedge PCLK) begin
    chk("d1.we",   int'(wr1.o_WE),   int'(e_we[0]));
    chk("d1.addr", int'(wr1.o_ADDR), e_addr[0]);
    chk("d1.data", int'(wr1.o_DATA), e_data[0]);
    chk("d1.done", int'(done1),      int'(e_done[0]));
    chk("d1.ok",   int'(ok1),        int'(e_ok[0]));
    chk("d1.busy", int'(busy1),      int'(e_busy[0]));
    chk("d2.we",   int'(wr2.o_WE),   int'(e_we[1]));
    chk("d2.addr", int'(wr2.o_ADDR), e_addr[1]);
    chk("d2.data", int'(wr2.o_DATA), e_data[1]);
    chk("d2.done", int'(done2),      int'(e_done[1]));
    chk("d2.ok",   int'(ok2),        int'(e_ok[1]));
    chk("d2.busy", int'(busy2),      int'(e_busy[1]));
    if (wr1.o_WE === 1'b1) begin mem1[int'(wr1.o_ADDR)] = int'(wr1.o_DATA); wc1++; end
    if (wr2.o_WE === 1'b1) begin mem2[int'(wr2.o_ADDR)] = int'(wr2.o_DATA); wc2++; end
    if (done1 === 1'b1) begin dc1++; lok1 = ok1; end
    if (done2 === 1'b1) begin dc2++; lok2 = ok2; end
  end

  task automatic tick();
    @(negedge PCLK);
  endtask

  // Pixel value for line l, position i is pbase + l*4 + i + 1.
  task automatic do_frame(input int nlines, input int short_line, input int long_line,
                          input bit coinc, input bit cap_fall, input bit cap_mid,
                          input int pbase, input bit gaps, input int rst_line);
    int len;
    CAP = cap_fall; VSYNC = 1; repeat (3) tick();
    VSYNC = 0; repeat (2) tick();
    for (int l = 0; l < nlines; l++) begin
      if (cap_mid && l == 1) CAP = 1;
      len = (l == short_line) ? 3 : (l == long_line) ? 5 : 4;
      HREF = 1; tick();
      for (int i = 0; i < len; i++) begin
        if (l == rst_line && i == 2) begin
          VALID = 0; RST_N = 0; repeat (2) tick(); RST_N = 1;
        end
        if (gaps && $urandom_range(0, 2) == 0) begin VALID = 0; tick(); end
        HREF = !(coinc && i == len - 1);
        VALID = 1; PIX = 12'(pbase + l * 4 + i + 1);
        tick();
      end
      VALID = 0; HREF = 0; repeat (2) tick();
    end
    VSYNC = 1; repeat (3) tick();
  endtask

  int wc_s, dc_s;

  initial begin
    RST_N = 0; VSYNC = 0; HREF = 0; VALID = 0; CAP = 0; PIX = '0;
    repeat (3) tick();
    chk("reset.we", int'(wr1.o_WE), 0);
    chk("reset.addr", int'(wr1.o_ADDR), 0);
    chk("reset.busy", int'(busy1), 0);
    chk("reset.ok", int'(ok2), 0);
    RST_N = 1;

    // Nominal 3x4 frame.
    do_frame(3, -1, -1, 0, 1, 0, 0, 0, -1);
    for (int i = 0; i < 12; i++) chk($sformatf("A.mem1[%0d]", i), mem1[i], i + 1);
    chk("A.dc1", dc1, 1); chk("A.ok1", int'(lok1), 1);
    chk("A.mem2[0]", mem2[0], 1); chk("A.mem2[1]", mem2[1], 3);
    chk("A.mem2[2]", mem2[2], 9); chk("A.mem2[3]", mem2[3], 11);
    chk("A.dc2", dc2, 1); chk("A.ok2", int'(lok2), 1);

    // Four lines: y saturates, err_long.
    do_frame(4, -1, -1, 0, 1, 0, 0, 0, -1);
    chk("B.ok1", int'(lok1), 0); chk("B.ok2", int'(lok2), 0); chk("B.dc2", dc2, 2);
    chk("B.mem2[2]", mem2[2], 9); chk("B.mem2[3]", mem2[3], 11);

    // Line 1 with 5 pixels: fifth dropped.
    wc_s = wc1;
    do_frame(3, -1, 1, 0, 1, 0, 'h80, 0, -1);
    chk("C.ok1", int'(lok1), 0); chk("C.writes1", wc1 - wc_s, 12);

    // Short line 0: next line still starts at address 4.
    do_frame(3, 0, -1, 0, 1, 0, 'h100, 0, -1);
    chk("D.ok1", int'(lok1), 0); chk("D.mem1[4]", mem1[4], 'h105);

    // Last pixel coincident with HREF fall on every line.
    do_frame(3, -1, -1, 1, 1, 0, 'h300, 0, -1);
    chk("E.mem1[3]", mem1[3], 'h304); chk("E.mem1[4]", mem1[4], 'h305);
    chk("E.mem1[11]", mem1[11], 'h30C); chk("E.ok1", int'(lok1), 1);

    // Reset mid-line 1: frame abandoned, next full frame captured from 0.
    wc_s = wc1; dc_s = dc1;
    do_frame(3, -1, -1, 0, 1, 0, 'h200, 0, 1);
    chk("F.writes1", wc1 - wc_s, 6); chk("F.dc1", dc1, dc_s);
    do_frame(3, -1, -1, 0, 1, 0, 'h400, 0, -1);
    chk("G.mem1[0]", mem1[0], 'h401); chk("G.dc1", dc1, dc_s + 1); chk("G.ok1", int'(lok1), 1);

    // Capture enable low at frame start, raised mid-frame.
    wc_s = wc1; dc_s = dc1;
    do_frame(3, -1, -1, 0, 0, 1, 'h500, 0, -1);
    chk("H.writes1", wc1 - wc_s, 0); chk("H.dc1", dc1, dc_s);
    do_frame(3, -1, -1, 0, 1, 0, 'h600, 0, -1);
    chk("I.mem1[0]", mem1[0], 'h601); chk("I.dc1", dc1, dc_s + 1);

    // Randomized frames checked cycle by cycle against the model.
    for (int f = 0; f < 30; f++) begin
      do_frame($urandom_range(2, 5),
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1,
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1,
               1'($urandom_range(0, 1)),
               ($urandom_range(0, 4) != 0),
               ($urandom_range(0, 5) == 0),
               int'($urandom_range(0, 'hE00)),
               1'b1,
               ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 1)) : -1);
    end

    repeat (4) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/frame_buffer_writer.md
Name: frame_buffer_writer

Overview:
- Downstream consumer of the RGB444 byte-pair deserializer.
- Takes 12-bit pixels with a one-cycle valid strobe, plus camera VSYNC/HREF.
- Frames on VSYNC, counts pixels and lines, and optionally decimates 2:1 in x and y.
- Emits registered write address, data and enable for a simple dual-port frame-buffer BRAM read by the display side.

Parameters:
- H_ACTIVE, 640, active pixels per camera line.
- V_ACTIVE, 480, active lines per camera frame.
- DECIM, 1, decimation factor; legal values 1 or 2 only, anything else is an elaboration error.
- ADDR_W, 19, address width; must satisfy 2**ADDR_W >= (H_ACTIVE/DECIM)*(V_ACTIVE/DECIM).

Ports:
- PCLK  in  1  pixel clock; everything is registered on its rising edge.
- RST_N  in  1  synchronous active-low reset, sampled on the PCLK rising edge.
- VSYNC  in  1  camera VSYNC; high during vertical blanking.
- HREF  in  1  camera HREF; high during active line.
- i_PIXEL  in  12  RGB444 pixel {R,G,B}.
- i_VALID  in  1  one-cycle strobe, i_PIXEL valid.
- i_CAPTURE_EN  in  1  when high at frame start, that frame is written.
- o_ADDR  out  ADDR_W  BRAM write address.
- o_DATA  out  12  BRAM write data.
- o_WE  out  1  BRAM write enable.
- o_FRAME_DONE  out  1  one-cycle pulse at end of a captured frame.
- o_FRAME_OK  out  1  status of last captured frame; valid when o_FRAME_DONE pulses, held until the next pulse.
- o_BUSY  out  1  high while in S_ACTIVE.

Behaviour:
- Edge detection: VSYNC and HREF registered once into vs_q and hr_q.
  - vs_rise = VSYNC & ~vs_q; vs_fall = ~VSYNC & vs_q.
  - hr_fall = ~HREF & hr_q.
- Reset (RST_N low at a clock edge):
  - state=S_SYNC; all counters 0; vs_q=hr_q=0.
  - o_ADDR=0, o_DATA=0, o_WE=0, o_FRAME_DONE=0, o_FRAME_OK=0, o_BUSY=0.
  - Reset mid-frame abandons the frame with no done pulse. The next capture never starts on a partial frame.
- States:
  - S_SYNC: wait for VSYNC high, then go to S_WAIT.
  - S_WAIT: on vs_fall, if i_CAPTURE_EN=1 go to S_ACTIVE and clear x, y, line_base and the error flags; otherwise stay in S_WAIT.
  - S_ACTIVE: on vs_rise go to S_WAIT and pulse o_FRAME_DONE in the next cycle.
- Pixel counting in S_ACTIVE, on i_VALID:
  - Pixel is kept iff x<H_ACTIVE, y<V_ACTIVE, and (DECIM==1 or (x[0]==0 and y[0]==0)).
  - Kept pixel: next cycle o_WE=1, o_DATA=i_PIXEL, o_ADDR=line_base+(x/DECIM). Latency from i_VALID to o_WE is exactly 1 cycle.
  - x increments by 1 saturating at H_ACTIVE.
  - x>=H_ACTIVE sets sticky err_long; the pixel is not written.
- Line end (hr_fall in S_ACTIVE):
  - x!=H_ACTIVE sets sticky err_short.
  - If the line was kept (y<V_ACTIVE and (DECIM==1 or y[0]==0)), line_base += H_ACTIVE/DECIM.
  - y increments saturating at V_ACTIVE; y>=V_ACTIVE at line end sets err_long.
  - x resets to 0.
- Simultaneous i_VALID and hr_fall in the same cycle: the pixel is processed first with the old x and line_base, then the line-end update applies.
- Simultaneous vs_rise and hr_fall: the line-end update applies, then the frame closes with the updated y.
- o_FRAME_OK = (y==V_ACTIVE) & ~err_short & ~err_long, registered with the o_FRAME_DONE pulse.
- o_WE is 0 in all states except the cycle after a kept pixel.
- o_ADDR and o_DATA hold their last values when o_WE=0.
- i_VALID outside S_ACTIVE is ignored.

Decomposition:
- Package ov7670_pkg:
  - typedef rgb444_t (12-bit packed struct r/g/b, 4 bits each).
  - fsm enum capture_state_t {S_SYNC, S_WAIT, S_ACTIVE}.
  - Constants OV_H_ACTIVE=640 and OV_V_ACTIVE=480.
- One sub-module: sync_edge_detect (register plus rise/fall outputs), instantiated for VSYNC and HREF.

Test Plan (H_ACTIVE=4, V_ACTIVE=3 unless noted):
- Reset, then VSYNC 1->0 with i_CAPTURE_EN=1; 3 lines of 4 valid pixels 0x001..0x00C; VSYNC rise -> writes at addr 0..11 with data 0x001..0x00C, each o_WE one cycle after i_VALID; o_FRAME_DONE pulse; o_FRAME_OK=1.
- DECIM=2, same frame with 4 lines -> writes only (x,y)∈{0,2}×{0,2}: addr0=0x001, addr1=0x003, addr2=0x009, addr3=0x00B; o_FRAME_OK=0 because y saturated (4 lines > V_ACTIVE=3 sets err_long).
- Line 1 with 5 valid pixels -> 5th not written, o_FRAME_OK=0. Separate frame with a 3-pixel line -> o_FRAME_OK=0, and the next line still starts at addr 4.
- Assert RST_N low mid-line 1 with VSYNC low -> outputs 0, no writes, no o_FRAME_DONE until a full VSYNC high->low cycle; then capture starts at addr 0.
- i_CAPTURE_EN=0 at vs_fall -> frame ignored, o_WE stays 0, no o_FRAME_DONE. Raise it mid-frame -> capture begins only at the next vs_fall.
- i_VALID coincident with hr_fall on the last pixel -> pixel written at old line_base+3; next line starts at line_base+4.
